// File: rtl/cla_seq_arbiter_pkg.sv
// Shared types and constants for the sequential CLA arbiter.
// Pure declarations; no timing or flow control of its own.
// Used by the controller and the adder slice.
package cla_seq_arbiter_pkg;

    localparam int WIDTH = 16;
    localparam int SLICE = 6;
    localparam int NPASS = 3;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DONE = 2'd2
    } state_t;

    // Captured operation: B is stored already inverted for subtract.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             id;
    } op_t;

    // Operand bits fed to the slice on a given pass; the top pass is zero-padded.
    function automatic logic [SLICE-1:0] slice_of(input logic [WIDTH-1:0] v,
                                                  input logic [1:0]       pass);
        logic [SLICE-1:0] r;
        case (pass)
            2'd0:    r = v[5:0];
            2'd1:    r = v[11:6];
            default: r = {2'b00, v[15:12]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cla_6bit_ci.sv
// 6-bit carry-lookahead adder slice with carry in and carry out.
// Purely combinational, zero latency.
// No flow control; the caller registers the result.
import cla_seq_arbiter_pkg::*;

module cla_6bit_ci (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);

    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   gg;
    logic [SLICE:0]   c;

    assign p  = a ^ b;
    assign g  = a & b;
    assign gg = {g, ci};

    // c[i] = OR over k of gg[k] & p[k..i-1]: every carry is a flat two-level term.
    always_comb begin
        logic term;
        logic acc;
        term = 1'b0;
        acc  = 1'b0;
        c    = '0;
        c[0] = ci;
        for (int i = 1; i <= SLICE; i++) begin
            acc = 1'b0;
            for (int k = 0; k <= i; k++) begin
                term = gg[k];
                for (int m = k; m < i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            c[i] = acc;
        end
    end

    assign s  = p ^ c[SLICE-1:0];
    assign co = c[SLICE];

endmodule

// File: rtl/cla_seq_arbiter.sv
// Round-robin arbiter sharing one 6-bit CLA slice for 16-bit add/sub.
// Latency: 3 edges from request accept to rsp_valid.
// Backpressure: result holds in DONE until rsp_ready; no request is accepted outside IDLE.
import cla_seq_arbiter_pkg::*;

module cla_seq_arbiter (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    op_t              op_q;
    logic             carry_q;
    logic [1:0]       pass_q;
    logic             rr_last;
    logic [11:0]      low_q;

    logic             gnt_vld;
    logic             gnt_id;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_sub;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_co;
    logic             last_pass;

    // Grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = REQ0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~rr_last;
        end else if (req1_valid) begin
            gnt_id = REQ1;
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign accept     = rst_n && (state == IDLE) && gnt_vld;
    assign req0_ready = accept && (gnt_id == REQ0);
    assign req1_ready = accept && (gnt_id == REQ1);
    assign busy       = (state != IDLE);

    assign sel_a   = (gnt_id == REQ1) ? req1_a   : req0_a;
    assign sel_b   = (gnt_id == REQ1) ? req1_b   : req0_b;
    assign sel_sub = (gnt_id == REQ1) ? req1_sub : req0_sub;

    assign sl_a      = slice_of(op_q.a, pass_q);
    assign sl_b      = slice_of(op_q.b, pass_q);
    assign last_pass = (pass_q == 2'(NPASS - 1));

    cla_6bit_ci u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = PASS;
            PASS:    if (last_pass) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            carry_q   <= 1'b0;
            pass_q    <= 2'd0;
            rr_last   <= REQ1;
            low_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q.a  <= sel_a;
                        op_q.b  <= sel_b ^ {WIDTH{sel_sub}};
                        op_q.id <= gnt_id;
                        carry_q <= sel_sub;
                        rr_last <= gnt_id;
                        pass_q  <= 2'd0;
                    end
                end
                PASS: begin
                    pass_q <= pass_q + 2'd1;
                    if (pass_q == 2'd0) begin
                        low_q[5:0] <= sl_s;
                        carry_q    <= sl_co;
                    end else if (pass_q == 2'd1) begin
                        low_q[11:6] <= sl_s;
                        carry_q     <= sl_co;
                    end else begin
                        // Slice bit 4 sees only the carry out of bit 15.
                        rsp_sum   <= {sl_s[3:0], low_q};
                        rsp_cout  <= sl_s[4];
                        rsp_ovf   <= (op_q.a[WIDTH-1] == op_q.b[WIDTH-1]) &&
                                     (sl_s[3] != op_q.a[WIDTH-1]);
                        rsp_id    <= op_q.id;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_arbiter.sv
// Scoreboard bench for the shared-slice add/sub arbiter.
module tb_cla_seq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_sub;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
    logic [15:0] rsp_sum;

    always #5 clk = ~clk;

    cla_seq_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic last_id = 1'b1;

    function automatic exp_t model(input logic id, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub);
        exp_t        e;
        logic [15:0] bp;
        logic [16:0] full;
        bp     = b ^ {16{sub}};
        full   = {1'b0, a} + {1'b0, bp} + {16'd0, sub};
        e.id   = id;
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (a[15] == bp[15]) && (full[15] != a[15]);
        return e;
    endfunction

    // Every completed response handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got id=%0d sum=%h", rsp_id, rsp_sum);
            end else begin
                mon_e = sb.pop_front();
                if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {mon_e.id, mon_e.sum, mon_e.cout, mon_e.ovf}) begin
                    errors++;
                    $display("FAIL rsp id/sum/cout/ovf got %0d/%h/%0d/%0d want %0d/%h/%0d/%0d",
                             rsp_id, rsp_sum, rsp_cout, rsp_ovf,
                             mon_e.id, mon_e.sum, mon_e.cout, mon_e.ovf);
                end
            end
        end
    end

    task automatic drive(input logic id, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic sub);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
        end
    endtask

    // Issue one op, push its expectation, scramble operands after accept, count edges to rsp_valid.
    task automatic send(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, output int lat);
        int n;
        drive(id, 1'b1, a, b, sub);
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) break;
        end
        if (n == 40) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got no ready want ready for id=%0d", id);
        end
        sb.push_back(model(id, a, b, sub));
        last_id = id;
        @(posedge clk);
        #1;
        drive(id, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 16'h1234, 16'h0FCD, 1'b0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, busy, req0_ready} !== 3'b000) begin
                errors++;
                $display("FAIL reset_ctl valid/busy/ready got %b want 000", {rsp_valid, busy, req0_ready});
            end
        end
        checks++;
        if ({rsp_sum, rsp_cout, rsp_ovf, rsp_id} !== 19'd0) begin
            errors++;
            $display("FAIL reset_rsp got sum=%h cout=%0d ovf=%0d id=%0d want 0", rsp_sum, rsp_cout, rsp_ovf, rsp_id);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL idle_ready got r0/r1=%b want 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_req0_add();
        int lat;
        send(1'b0, 16'h1234, 16'h0FCD, 1'b0, lat);
        checks++;
        if (lat !== 3 || rsp_sum !== 16'h2201) begin
            errors++;
            $display("FAIL req0_add latency/sum got %0d/%h want 3/2201", lat, rsp_sum);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_req1_sub();
        logic [15:0] ta[2] = '{16'h0005, 16'h8000};
        logic [15:0] tb[2] = '{16'h0007, 16'h0001};
        int lat;
        for (int i = 0; i < 2; i++) begin
            send(1'b1, ta[i], tb[i], 1'b1, lat);
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL req1_sub_latency case %0d got %0d want 3", i, lat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] ta[4] = '{16'h0FFF, 16'hFFFF, 16'h7FFF, 16'h003F};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send(1'(i), ta[i], 16'h0001, 1'b0, lat);
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL boundary_latency case %0d got %0d want 3", i, lat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        logic order[4];
        logic first;
        int   acc = 0;
        int   bad_busy = 0;
        first = ~last_id;
        drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        drive(1'b1, 1'b1, 16'h5000, 16'h6000, 1'b1);
        for (int cyc = 0; cyc < 60 && acc < 4; cyc++) begin
            @(negedge clk);
            if (busy === 1'b1 && (req0_ready !== 1'b0 || req1_ready !== 1'b0)) bad_busy++;
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                order[acc] = req1_ready;
                sb.push_back(req1_ready ? model(1'b1, 16'h5000, 16'h6000, 1'b1)
                                        : model(1'b0, 16'h1111, 16'h2222, 1'b0));
                last_id = req1_ready;
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc == 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        checks++;
        if (acc !== 4 || bad_busy !== 0) begin
            errors++;
            $display("FAIL rr_accepts got %0d accepts %0d busy-ready want 4/0", acc, bad_busy);
        end
        for (int i = 0; i < acc; i++) begin
            checks++;
            if (order[i] !== (first ^ 1'(i))) begin
                errors++;
                $display("FAIL rr_order slot %0d got %0d want %0d", i, order[i], first ^ 1'(i));
            end
        end
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        rsp_ready = 1'b0;
        e = model(1'b0, 16'h4321, 16'h1111, 1'b1);
        send(1'b0, 16'h4321, 16'h1111, 1'b1, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL bp_latency got %0d want 3", lat);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, req0_ready, req1_ready} !==
                {1'b1, e.sum, e.cout, e.ovf, e.id, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold got v=%0d sum=%h cout=%0d ovf=%0d rdy=%b want v=1 sum=%h cout=%0d ovf=%0d rdy=00",
                         rsp_valid, rsp_sum, rsp_cout, rsp_ovf, {req0_ready, req1_ready}, e.sum, e.cout, e.ovf);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== e.sum || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got v=%0d sum=%h busy=%0d want v=0 sum=%h busy=0", rsp_valid, rsp_sum, busy, e.sum);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int n;
        int highs = 0;
        int lat;
        drive(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0);
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (req1_ready === 1'b1) break;
        end
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) highs++;
        end
        checks++;
        if (highs !== 0 || n == 10) begin
            errors++;
            $display("FAIL abort_rsp got %0d valid cycles (accept wait %0d) want 0", highs, n);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'hABCD, 16'h1234, 1'b1);
        drive(1'b1, 1'b1, 16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_grant got r0/r1=%b want 10", {req0_ready, req1_ready});
        end
        sb.push_back(model(1'b0, 16'hABCD, 16'h1234, 1'b1));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL post_reset_latency got %0d want 3", lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        test_reset();
        test_req0_add();
        test_req1_sub();
        test_boundaries();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        repeat (4) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
